// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared op constants, shifter modes, instruction categories and the control bundle.
package ctrl_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    typedef enum logic [1:0] {
        AM_ROTATE_RIGHT = 2'b00,
        AM_PASS_RM      = 2'b01,
        AM_ZERO_EXTEND  = 2'b10,
        AM_SHIFT_RM     = 2'b11
    } am_e;

    typedef enum logic [1:0] {CAT_NONE, CAT_DP, CAT_LS, CAT_BR} cat_e;

    typedef struct packed {
        logic       valid;
        logic       rf_en;
        logic [3:0] alu_op;
        am_e        am;
        logic       s_bit;
        logic       load;
        logic       rw;
        logic       size;
        logic       dmem_en;
        logic       branch;
        logic       bl;
        logic [3:0] rd;
    } ctrl_t;

    function automatic cat_e category(input logic [2:0] f);
        return f[2:1] == 2'b00 ? CAT_DP : f[2:1] == 2'b01 ? CAT_LS : f == 3'b101 ? CAT_BR : CAT_NONE;
    endfunction

    function automatic ctrl_t qualify(input ctrl_t c);
        return c.valid ? c : '0;
    endfunction
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational instruction-to-control-bundle decode.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output ctrl_t       ctrl
);
    cat_e cat;
    logic unused_bits;

    assign cat = valid ? category(instr[27:25]) : CAT_NONE;
    // condition, Rn and Rm fields are consumed by the hazard logic, not by decode
    assign unused_bits = ^{instr[31:28], instr[23], instr[19:16], instr[3:0]};

    always_comb begin
        ctrl = '0;
        if (cat == CAT_DP) begin
            ctrl.valid  = 1'b1;
            ctrl.rf_en  = 1'b1;
            ctrl.s_bit  = instr[20];
            ctrl.rd     = instr[15:12];
            ctrl.alu_op = instr[24:21] <= ALU_ORR ? instr[24:21] : ALU_AND;
            ctrl.am     = instr[25] ? AM_ROTATE_RIGHT : AM_SHIFT_RM;
        end else if (cat == CAT_LS) begin
            ctrl.valid   = 1'b1;
            ctrl.dmem_en = 1'b1;
            ctrl.load    = instr[20];
            ctrl.rw      = instr[20];
            ctrl.rf_en   = instr[20];
            ctrl.size    = instr[22];
            ctrl.rd      = instr[15:12];
            ctrl.am      = instr[25] ? AM_ZERO_EXTEND : instr[11:4] == 8'd0 ? AM_PASS_RM : AM_SHIFT_RM;
        end else if (cat == CAT_BR) begin
            ctrl.valid  = 1'b1;
            ctrl.branch = 1'b1;
            ctrl.bl     = instr[24];
            ctrl.rf_en  = instr[24];
            ctrl.rd     = instr[24] ? 4'd14 : 4'd0;
        end
    end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decode plus NUM_STAGES control stage registers with load-use, stall and flush handling.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ALU_OP_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         id_instr,
    input  logic                id_valid,
    input  logic                stall_in,
    input  logic                flush,
    output logic                hazard_stall,
    output logic                ex_valid,
    output logic                ex_rf_en,
    output logic                ex_s_bit,
    output logic                ex_branch,
    output logic                ex_bl,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [1:0]          ex_am,
    output logic                mem_valid,
    output logic                mem_en,
    output logic                mem_rw,
    output logic                mem_size,
    output logic                mem_load,
    output logic                wb_valid,
    output logic                wb_rf_en,
    output logic                wb_load,
    output logic [3:0]          wb_rd
);
    ctrl_t dec;
    ctrl_t stage [NUM_STAGES];
    ctrl_t ex, mem, wb;
    logic  rm_form;

    ctrl_decoder u_dec (.instr(id_instr), .valid(id_valid), .ctrl(dec));

    assign ex  = qualify(stage[0]);
    assign mem = qualify(stage[1]);
    assign wb  = qualify(stage[NUM_STAGES-1]);

    // Rm is a register source only for the shifted/pass-through operand modes
    assign rm_form      = dec.am == AM_PASS_RM || dec.am == AM_SHIFT_RM;
    assign hazard_stall = ex.valid & ex.load & id_valid &
                          (ex.rd == id_instr[19:16] || (rm_form && ex.rd == id_instr[3:0]));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) stage[i] <= '0;
        end else if (!stall_in) begin
            stage[0] <= flush || hazard_stall ? '0 : dec;
            for (int i = 1; i < NUM_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign ex_valid  = ex.valid;
    assign ex_rf_en  = ex.rf_en;
    assign ex_s_bit  = ex.s_bit;
    assign ex_branch = ex.branch;
    assign ex_bl     = ex.bl;
    assign ex_alu_op = ALU_OP_W'(ex.alu_op);
    assign ex_am     = ex.am;
    assign mem_valid = mem.valid;
    assign mem_en    = mem.dmem_en;
    assign mem_rw    = mem.rw;
    assign mem_size  = mem.size;
    assign mem_load  = mem.load;
    assign wb_valid  = wb.valid;
    assign wb_rf_en  = wb.rf_en;
    assign wb_load   = wb.load;
    assign wb_rd     = wb.rd;
endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 The block SHALL take parameter NUM_STAGES, default 3: control stages after decode, legal 3..6; stage 0 = EX, stage 1 = MEM, stage NUM_STAGES-1 = WB.
REQ-002 The block SHALL take parameter ALU_OP_W, default 4: alu_op width; values zero-extended from the 4-bit op table.
REQ-003 The block SHALL have these ports, each as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_instr  in  32  instruction in decode.
- id_valid  in  1  id_instr is live.
- stall_in  in  1  freeze all stage registers.
- flush  in  1  kill the decode instruction (taken branch).
- hazard_stall  out  1  load-use stall request to fetch/decode.
- ex_valid, ex_rf_en, ex_s_bit, ex_branch, ex_bl  out  1 each  EX-stage controls.
- ex_alu_op  out  ALU_OP_W  EX-stage ALU operation.
- ex_am  out  2  shifter mode: 00 ROTATE_RIGHT, 01 PASS_RM, 10 ZERO_EXTEND, 11 SHIFT_RM.
- mem_valid, mem_en, mem_rw, mem_size, mem_load  out  1 each  MEM-stage controls; mem_rw 1 = read, mem_size 1 = byte.
- wb_valid, wb_rf_en, wb_load  out  1 each  WB-stage controls.
- wb_rd  out  4  WB destination register.

Function
REQ-004 The decode path SHALL be combinational from id_instr to a control bundle: valid, rf_en, alu_op, am, s_bit, load, rw, size, dmem_en, branch, bl, rd.
REQ-005 Data processing instructions (bits[27:25] = 00x) SHALL decode as follows:
- rf_en = 1; s_bit = bit20; rd = bits[15:12].
- alu_op = bits[24:21] when bits[24:21] <= 1100, else 0000.
- am = ROTATE_RIGHT when bit25 = 1, else SHIFT_RM.
REQ-006 Load/store instructions (bits[27:25] = 01x) SHALL decode as follows:
- dmem_en = 1; load = rw = rf_en = bit20; size = bit22; rd = bits[15:12].
- am = ZERO_EXTEND when bit25 = 1; else PASS_RM when bits[11:4] = 0; else SHIFT_RM.
REQ-007 Branch instructions (bits[27:25] = 101) SHALL decode as branch = 1, bl = rf_en = bit24, rd = 14 when bl = 1.
REQ-008 All other categories, and id_valid = 0, SHALL decode to an all-zero bundle (bubble).
REQ-009 The bundle of an instruction decoded in cycle N SHALL appear at stage k outputs in cycle N+1+k when no stall occurs.
REQ-010 Stage k+1 SHALL load stage k on every edge unless stall_in = 1.
REQ-011 hazard_stall SHALL be 1, combinationally, when all of the following hold:
- ex_valid & ex_load & id_valid;
- ex rd equals id_instr[19:16], or equals id_instr[3:0] for a register-operand form.
REQ-012 While hazard_stall = 1, a bubble SHALL enter EX, the later stages SHALL advance, and the decode instruction SHALL be re-presented by upstream.
REQ-013 flush = 1 SHALL load a bubble into EX; the later stages SHALL advance normally.
REQ-014 When events coincide, priority SHALL be reset > stall_in > flush > hazard.
REQ-015 While stall_in = 1, every stage SHALL hold, including the valid bits.
REQ-016 hazard_stall SHALL still be evaluated while stall_in = 1.
REQ-017 Every stage output SHALL be qualified by its stage's valid bit: an invalid stage drives all of its control outputs 0.

Reset
REQ-018 On a clk edge with reset_n = 0, all stage registers SHALL clear to the all-zero bundle.
REQ-019 Reset SHALL take effect regardless of stall_in or flush, including mid-stream.
REQ-020 All outputs SHALL read 0 in the cycle after reset, with hazard_stall = 0 because ex_valid = 0.

Structure
REQ-021 The shared package ctrl_pkg SHALL hold:
- the ALU op constants 0000..1100;
- the AM constants;
- the category codes;
- the control-bundle typedef.
REQ-022 Decode SHALL live in one combinational sub-module, ctrl_decoder.
REQ-023 The stage registers SHALL be a NUM_STAGES-entry array of bundles inside pipelined_control_unit.

Verification
REQ-024 ADD test: id_instr = 0xE0821003, id_valid = 1 -> next cycle ex_valid = 1, ex_rf_en = 1, ex_alu_op = 0100, ex_am = 11; two cycles later wb_rd = 1, wb_rf_en = 1.
REQ-025 Load-use test: 0xE5912000 (LDR) followed by 0xE0823004 -> with the LDR in EX, hazard_stall = 1 for exactly one cycle and a bubble enters EX (ex_valid = 0 next cycle); then the ADD enters EX once with no duplicate at WB.
REQ-026 BL test: 0xEB000010 -> ex_branch = 1, ex_bl = 1; at WB, wb_rf_en = 1 and wb_rd = 14.
REQ-027 Stall/flush test: stall_in = 1 for 3 cycles mid-stream -> all outputs frozen; then flush = 1 with the LDR in decode -> ex_valid = 0 and the LDR never reaches mem_en.
REQ-028 Reset test: reset_n = 0 for one edge with three valid instructions in flight -> all valid outputs 0 next cycle and hazard_stall = 0.
REQ-029 Depth test: NUM_STAGES = 5 -> the WB outputs of an instruction decoded in cycle N appear in cycle N+5.
